la_stream_buffer: RTL and testbench
===================================

LA_STREAM_BUFFER -- requirements
Module: la_stream_buffer

Interface
REQ-001 SHALL have parameter DW, default 32, payload width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 4, entry count; power of two, >=2.
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-1, almost-full threshold (1..DEPTH).
REQ-004 SHALL have parameter OPT_LOWPOWER, default 0, forces o_data to zero whenever o_valid is low.
REQ-005 SHALL have port i_clk  input  1  sole clock; all state updates on rising edge.
REQ-006 SHALL have port i_reset_n  input  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have port i_flush  input  1  synchronous discard of all stored entries.
REQ-008 SHALL have port i_valid  input  1  upstream beat valid.
REQ-009 SHALL have port o_ready  output  1  buffer can accept a beat.
REQ-010 SHALL have port i_data  input  DW  upstream payload.
REQ-011 SHALL have port o_valid  output  1  downstream beat valid.
REQ-012 SHALL have port i_ready  input  1  downstream accepts beat.
REQ-013 SHALL have port o_data  output  DW  downstream payload.
REQ-014 SHALL have port o_level  output  $clog2(DEPTH+1)  current stored-entry count.
REQ-015 SHALL have port o_almost_full  output  1  high when o_level >= AF_LEVEL.

Function
REQ-016 SHALL store entries in a circular array with read/write pointers of $clog2(DEPTH)+1 bits; full = MSBs differ and low bits equal, empty = pointers equal.
REQ-017 SHALL define push = i_valid && o_ready and pop = o_valid && i_ready.
REQ-018 SHALL drive o_ready = !full, from registered state only; no combinational path from i_ready or i_valid to o_ready.
REQ-019 SHALL drive o_valid = !empty and o_data = entry at read pointer (zero when empty and OPT_LOWPOWER=1) in the default build.
REQ-020 SHALL give 1-cycle latency in the default build: beat pushed at edge N is visible on o_valid/o_data after edge N.
REQ-021 SHALL update o_level by +1 on push-only, -1 on pop-only, unchanged on simultaneous push and pop; never exceeds DEPTH, never wraps below 0.
REQ-022 SHALL when full accept no beat; simultaneous pop while full frees one slot visible on o_ready the next cycle only.
REQ-023 SHALL hold o_valid high and o_data stable while o_valid && !i_ready.
REQ-024 SHALL on i_flush reset both pointers and o_level to 0 at the next edge; flush takes priority over push and pop in the same cycle (that beat is dropped, that pop is still counted as transferred downstream).
REQ-025 SHALL preserve order: beats leave in exactly the order accepted, no duplication, no loss except by flush or reset.

Reset
REQ-026 SHALL on i_reset_n low, asynchronously clear pointers and o_level; o_valid=0, o_ready=1, o_almost_full=0 (AF_LEVEL>0), o_data=0 if OPT_LOWPOWER.
REQ-027 SHALL not require storage-array contents to be reset; reset mid-transfer discards all entries.
REQ-028 SHALL release reset synchronously with respect to i_clk (deassertion synchronised upstream of this block).

Configuration
REQ-029 SHALL honour macro LA_STREAM_BUFFER_BYPASS_EN: when defined and buffer empty, i_valid/i_data pass combinationally to o_valid/o_data (0-cycle latency) and a beat taken downstream in that cycle is not stored; when undefined, every beat is stored first (REQ-020). o_ready rule (REQ-018) is identical in both builds.

Structure
REQ-030 SHALL place no block-specific typedefs in a shared package; pointer/level widths are local parameters derived from DEPTH.
REQ-031 SHALL be a single module; storage array inferred inline, no sub-module.

Verification
REQ-032 SHALL cover fill: DEPTH=4, i_ready=0, push 0x11,0x22,0x33,0x44 -> o_level 1..4, o_ready=0 after 4th, o_almost_full=1 from level 3.
REQ-033 SHALL cover drain order: from full, i_ready=1 for 4 cycles -> o_data 0x11,0x22,0x33,0x44, then o_valid=0, o_level=0.
REQ-034 SHALL cover streaming: i_valid=i_ready=1 continuously with counting data -> o_level constant 1 (default) or 0 (BYPASS_EN), no gaps after first output.
REQ-035 SHALL cover full with simultaneous pop: full, i_ready=1, i_valid=1 -> this cycle no push, o_ready=1 next cycle, o_level 3.
REQ-036 SHALL cover flush: level 3, i_flush=1 with i_valid=1 -> next cycle o_level=0, o_valid=0, pushed beat never appears.
REQ-037 SHALL cover async reset mid-stream: i_reset_n low between edges at level 2 -> o_valid=0, o_ready=1 immediately, without waiting for a clock.

Source files
------------

// File: rtl/la_stream_buffer_pkg.sv
// Shared helpers for stream-buffer style blocks; holds nothing specific to one block.
package la_stream_buffer_pkg;

    // Bit width needed to index n items, never less than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/la_stream_buffer.sv
// Valid/ready FIFO buffer with level and almost-full reporting.
// Optional combinational bypass when empty: define LA_STREAM_BUFFER_BYPASS_EN.
module la_stream_buffer
    import la_stream_buffer_pkg::*;
#(
    parameter int unsigned DW           = 32,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned AF_LEVEL     = DEPTH - 1,
    parameter bit          OPT_LOWPOWER = 1'b0
) (
    input  logic                             i_clk,
    input  logic                             i_reset_n,
    input  logic                             i_flush,
    input  logic                             i_valid,
    output logic                             o_ready,
    input  logic [DW-1:0]                    i_data,
    output logic                             o_valid,
    input  logic                             i_ready,
    output logic [DW-1:0]                    o_data,
    output logic [idx_width(DEPTH+1)-1:0]    o_level,
    output logic                             o_almost_full
);

    localparam int unsigned AW = idx_width(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned LW = idx_width(DEPTH + 1);

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;

    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          store;
    logic          pop_mem;
    logic          valid_raw;
    logic [DW-1:0] data_raw;

    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);

    // o_ready depends only on registered pointers in both builds.
    assign o_ready = !full;

`ifdef LA_STREAM_BUFFER_BYPASS_EN
    assign valid_raw = empty ? i_valid : 1'b1;
    assign data_raw  = empty ? i_data  : mem_q[rd_ptr_q[AW-1:0]];
`else
    assign valid_raw = !empty;
    assign data_raw  = mem_q[rd_ptr_q[AW-1:0]];
`endif

    assign o_valid = valid_raw;
    assign o_data  = (OPT_LOWPOWER && !valid_raw) ? '0 : data_raw;

    assign push    = i_valid && o_ready;
    assign pop     = o_valid && i_ready;
    assign pop_mem = pop && !empty;

`ifdef LA_STREAM_BUFFER_BYPASS_EN
    // A beat consumed straight through while empty never occupies a slot.
    assign store = push && !(empty && pop);
`else
    assign store = push;
`endif

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (store)   wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop_mem) rd_ptr_d = rd_ptr_q + PW'(1);
            case ({store, pop_mem})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage carries no reset; stale entries are unreachable once pointers clear.
    always_ff @(posedge i_clk) begin
        if (store && !i_flush) begin
            mem_q[wr_ptr_q[AW-1:0]] <= i_data;
        end
    end

    assign o_level       = level_q;
    assign o_almost_full = (level_q >= LW'(AF_LEVEL));

endmodule

// File: tb/tb_la_stream_buffer.sv
// Bench for la_stream_buffer: fixed vector table, corner sequences and random traffic vs a queue model.
module tb_la_stream_buffer;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int AFL   = 3;

    logic          i_clk = 1'b0;
    logic          i_reset_n = 1'b0;
    logic          i_flush = 1'b0;
    logic          i_valid = 1'b0;
    logic          o_ready;
    logic [DW-1:0] i_data = '0;
    logic          o_valid;
    logic          i_ready = 1'b0;
    logic [DW-1:0] o_data;
    logic [2:0]    o_level;
    logic          o_almost_full;

    int n_vec = 0;
    int n_bad = 0;

    logic [DW-1:0] q[$];

    logic          obs_ready, obs_valid, obs_af;
    logic [DW-1:0] obs_data;
    int            obs_level;

`ifdef LA_STREAM_BUFFER_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    la_stream_buffer #(
        .DW(DW), .DEPTH(DEPTH), .AF_LEVEL(AFL), .OPT_LOWPOWER(1'b1)
    ) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_flush(i_flush),
        .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data),
        .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data),
        .o_level(o_level), .o_almost_full(o_almost_full)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time exceeded, got no finish, required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // One clock: drive inputs, compare against the queue model, then advance the model.
    task automatic cycle(input logic v, input logic [31:0] d, input logic r, input logic f);
        logic          m_empty, e_valid, e_ready, take, put;
        logic [31:0]   e_data;
        @(negedge i_clk);
        i_valid = v; i_data = d; i_ready = r; i_flush = f;
        #1;
        m_empty = (q.size() == 0);
        e_ready = (q.size() < DEPTH);
        if (!m_empty) begin
            e_valid = 1'b1; e_data = q[0];
        end else if (BYP && v) begin
            e_valid = 1'b1; e_data = d;
        end else begin
            e_valid = 1'b0; e_data = '0;
        end
        obs_ready = o_ready; obs_valid = o_valid; obs_data = o_data;
        obs_level = int'(o_level); obs_af = o_almost_full;
        check("model_ready", {31'b0, o_ready}, {31'b0, e_ready});
        check("model_valid", {31'b0, o_valid}, {31'b0, e_valid});
        check("model_data",  o_data, e_data);
        check("model_level", {29'b0, o_level}, q.size());
        check("model_af",    {31'b0, o_almost_full}, {31'b0, (q.size() >= AFL)});
        take = e_valid && r;
        put  = v && e_ready;
        @(posedge i_clk);
        if (f) begin
            q.delete();
        end else begin
            if (take && !m_empty) void'(q.pop_front());
            if (put && !(m_empty && take)) q.push_back(d);
        end
    endtask

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        r;
        int          lvl;
        logic        rdy;
        logic        vld;
        logic [31:0] dat;
        logic        af;
    } vec_t;

    vec_t tbl[10];

    initial begin
        tbl[0] = '{1'b1, 32'h11, 1'b0, 0, 1'b1, BYP,  BYP ? 32'h11 : 32'h0, 1'b0};
        tbl[1] = '{1'b1, 32'h22, 1'b0, 1, 1'b1, 1'b1, 32'h11, 1'b0};
        tbl[2] = '{1'b1, 32'h33, 1'b0, 2, 1'b1, 1'b1, 32'h11, 1'b0};
        tbl[3] = '{1'b1, 32'h44, 1'b0, 3, 1'b1, 1'b1, 32'h11, 1'b1};
        tbl[4] = '{1'b0, 32'h00, 1'b0, 4, 1'b0, 1'b1, 32'h11, 1'b1};
        tbl[5] = '{1'b0, 32'h00, 1'b1, 4, 1'b0, 1'b1, 32'h11, 1'b1};
        tbl[6] = '{1'b0, 32'h00, 1'b1, 3, 1'b1, 1'b1, 32'h22, 1'b1};
        tbl[7] = '{1'b0, 32'h00, 1'b1, 2, 1'b1, 1'b1, 32'h33, 1'b0};
        tbl[8] = '{1'b0, 32'h00, 1'b1, 1, 1'b1, 1'b1, 32'h44, 1'b0};
        tbl[9] = '{1'b0, 32'h00, 1'b0, 0, 1'b1, 1'b0, 32'h00, 1'b0};

        // Reset state before any clock edge.
        #2;
        check("rst_valid", {31'b0, o_valid}, 0);
        check("rst_ready", {31'b0, o_ready}, 1);
        check("rst_level", {29'b0, o_level}, 0);
        check("rst_af",    {31'b0, o_almost_full}, 0);
        check("rst_data",  o_data, 0);
        @(negedge i_clk);
        i_reset_n = 1'b1;

        // Fill then drain.
        for (int i = 0; i < 10; i++) begin
            cycle(tbl[i].v, tbl[i].d, tbl[i].r, 1'b0);
            check($sformatf("tbl%0d_level", i), obs_level, tbl[i].lvl);
            check($sformatf("tbl%0d_ready", i), {31'b0, obs_ready}, {31'b0, tbl[i].rdy});
            check($sformatf("tbl%0d_valid", i), {31'b0, obs_valid}, {31'b0, tbl[i].vld});
            check($sformatf("tbl%0d_data", i),  obs_data, tbl[i].dat);
            check($sformatf("tbl%0d_af", i),    {31'b0, obs_af}, {31'b0, tbl[i].af});
        end

        // Full with simultaneous pop and push attempt.
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'hA1 + i, 1'b0, 1'b0);
        cycle(1'b1, 32'h55, 1'b1, 1'b0);
        check("fullpop_ready_same", {31'b0, obs_ready}, 0);
        check("fullpop_data", obs_data, 32'hA1);
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
        check("fullpop_level", obs_level, 3);
        check("fullpop_ready_next", {31'b0, obs_ready}, 1);
        check("fullpop_head", obs_data, 32'hA2);

        // Flush beats a concurrent push.
        cycle(1'b1, 32'h66, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
        check("flush_level", obs_level, 0);
        check("flush_valid", {31'b0, obs_valid}, 0);
        cycle(1'b1, 32'h77, 1'b0, 1'b0);
        cycle(1'b1, 32'h78, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
        check("preflush_head", obs_data, 32'h77);
        check("pre_reset_level", obs_level, 2);

        // Asynchronous reset between edges.
        #2;
        i_reset_n = 1'b0;
        #1;
        check("arst_valid", {31'b0, o_valid}, 0);
        check("arst_ready", {31'b0, o_ready}, 1);
        check("arst_level", {29'b0, o_level}, 0);
        check("arst_af",    {31'b0, o_almost_full}, 0);
        check("arst_data",  o_data, 0);
        q.delete();
        @(negedge i_clk);
        i_reset_n = 1'b1;

        // Continuous streaming.
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 32'h100 + i, 1'b1, 1'b0);
            if (i >= 1) begin
                check("stream_level", obs_level, BYP ? 0 : 1);
                check("stream_valid", {31'b0, obs_valid}, 1);
            end
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Random traffic against the model.
        for (int i = 0; i < 500; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 39) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
